// File: rtl/ddr3_frame_reader.sv
// ddr3_frame_reader: streams complete frame buffers out of DDR3 through an
// Avalon-MM read port in fixed-length bursts, rotating round-robin between
// full buffers. It also services single-beat debug reads between frames.
module ddr3_frame_reader #(
  parameter int NUM_BUFFERS     = 4,
  parameter int IMAGE_WIDTH     = 1280,
  parameter int IMAGE_HEIGHT    = 1024,
  parameter int PIXELS_PER_WORD = 4,
  parameter int BURST_LEN       = 4,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic                      ddr3_clk,
  input  logic                      ddr3_reset,
  input  logic [NUM_BUFFERS-1:0]    buffer_full,
  input  logic [26*NUM_BUFFERS-1:0] buffer_offset,
  output logic [NUM_BUFFERS-1:0]    buffer_clear,
  output logic                      frame_done,
  output logic                      busy,
  input  logic                      test_rd,
  input  logic [25:0]               test_addr,
  output logic [127:0]              test_rd_data,
  output logic                      test_rd_done,
  input  logic                      data_fifo_almost_full,
  input  logic                      ddr3_avl_ready,
  output logic                      ddr3_avl_burstbegin,
  output logic                      ddr3_avl_read_req,
  output logic [3:0]                ddr3_avl_size,
  output logic [25:0]               ddr3_avl_addr,
  input  logic                      ddr3_avl_read_data_valid,
  input  logic [127:0]              ddr3_avl_read_data,
  output logic                      pix_data_valid
);

  localparam int WORDS  = IMAGE_WIDTH * IMAGE_HEIGHT / PIXELS_PER_WORD;
  localparam int BURSTS = WORDS / BURST_LEN;
  localparam int SEL_W  = $clog2(NUM_BUFFERS);
  localparam int BC_W   = $clog2(BURSTS) + 1;
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1) + 1;

  localparam logic [3:0]      BURST_SIZE = 4'(BURST_LEN);
  localparam logic [BC_W-1:0] LAST_BURST = BC_W'(BURSTS - 1);

  // Parameter sanity: the frame must split into whole words and whole bursts.
  if ((IMAGE_WIDTH * IMAGE_HEIGHT) % PIXELS_PER_WORD != 0) begin : g_bad_words
    $error("IMAGE_WIDTH*IMAGE_HEIGHT is not a multiple of PIXELS_PER_WORD");
  end
  if (WORDS % BURST_LEN != 0 || BURSTS < 1) begin : g_bad_bursts
    $error("frame word count is not a whole number of bursts");
  end
  if (NUM_BUFFERS < 2 || NUM_BUFFERS > 8) begin : g_bad_nbuf
    $error("NUM_BUFFERS must be within 2..8");
  end
  if (BURST_LEN < 1 || BURST_LEN > 8) begin : g_bad_burst
    $error("BURST_LEN must be within 1..8");
  end
  if (MAX_OUTSTANDING < BURST_LEN || MAX_OUTSTANDING % BURST_LEN != 0) begin : g_bad_maxo
    $error("MAX_OUTSTANDING must be a non-zero multiple of BURST_LEN");
  end

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    TEST_ISSUE,
    TEST_WAIT
  } state_t;

  state_t             state_reg, state_next;
  logic [SEL_W-1:0]   sel_reg, sel_next;
  logic [25:0]        addr_reg, addr_next;
  logic [3:0]         size_reg, size_next;
  logic               read_req_reg, read_req_next;
  logic [BC_W-1:0]    burst_count_reg, burst_count_next;
  logic [OUT_W-1:0]   outstanding_reg, outstanding_next;
  logic               test_pending_reg, test_pending_next;
  logic [25:0]        test_addr_reg, test_addr_next;
  logic [127:0]       test_rd_data_reg, test_rd_data_next;
  logic [NUM_BUFFERS-1:0] buffer_clear_reg, buffer_clear_next;
  logic               frame_done_reg, frame_done_next;
  logic               test_rd_done_reg, test_rd_done_next;

  logic               accept;
  logic               cmd_waiting;
  logic               can_issue;
  logic               rr_found;
  logic [SEL_W-1:0]   rr_idx;

  logic [25:0]        offset [NUM_BUFFERS];
  logic [SEL_W-1:0]   rr_cand [1:NUM_BUFFERS-1];

  // Unpack the flat offset bus and precompute the round-robin candidates
  // sel+1, sel+2, ... (modulo NUM_BUFFERS) in search order.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUFFERS; gi++) begin : g_offset
      assign offset[gi] = buffer_offset[26*gi +: 26];
    end
    for (gi = 1; gi < NUM_BUFFERS; gi++) begin : g_rr_cand
      assign rr_cand[gi] = SEL_W'((int'(sel_reg) + gi) % NUM_BUFFERS);
    end
  endgenerate

  assign accept      = read_req_reg && ddr3_avl_ready;
  assign cmd_waiting = read_req_reg && !ddr3_avl_ready;

  // First full buffer after the current one, never the current one itself.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = sel_reg;
    for (int k = NUM_BUFFERS - 1; k >= 1; k--) begin
      if (buffer_full[rr_cand[k]]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand[k];
      end
    end
  end

  // In-flight beat count: grows by the accepted command size, shrinks per
  // returned beat. Beats with nothing outstanding (left over from a reset)
  // are ignored so the counter cannot underflow.
  always_comb begin
    outstanding_next = outstanding_reg;
    if (accept) begin
      outstanding_next = outstanding_next + OUT_W'(size_reg);
    end
    if (ddr3_avl_read_data_valid && (outstanding_reg != '0)) begin
      outstanding_next = outstanding_next - OUT_W'(1);
    end
  end

  // A new burst may be requested only with downstream room and in-flight budget.
  assign can_issue = !data_fifo_almost_full &&
                     ((int'(outstanding_next) + BURST_LEN) <= MAX_OUTSTANDING);

  // Next-state and output decode for the read sequencer.
  always_comb begin
    state_next        = state_reg;
    sel_next          = sel_reg;
    addr_next         = addr_reg;
    size_next         = size_reg;
    read_req_next     = read_req_reg;
    burst_count_next  = burst_count_reg;
    test_pending_next = test_pending_reg;
    test_addr_next    = test_addr_reg;
    test_rd_data_next = test_rd_data_reg;
    buffer_clear_next = '0;
    frame_done_next   = 1'b0;
    test_rd_done_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (test_pending_reg) begin
          state_next        = TEST_ISSUE;
          addr_next         = test_addr_reg;
          size_next         = 4'd1;
          read_req_next     = 1'b1;
          test_pending_next = 1'b0;
        end else if (buffer_full[sel_reg]) begin
          state_next       = ISSUE;
          addr_next        = offset[sel_reg];
          size_next        = BURST_SIZE;
          burst_count_next = '0;
        end else if (rr_found) begin
          sel_next = rr_idx;
        end
      end

      ISSUE: begin
        if (accept) begin
          addr_next        = addr_reg + 26'(BURST_LEN);
          burst_count_next = burst_count_reg + BC_W'(1);
        end
        // A command still waiting for ready keeps read_req/addr/size frozen.
        if (!cmd_waiting) begin
          if (accept && (burst_count_reg == LAST_BURST)) begin
            state_next    = DRAIN;
            read_req_next = 1'b0;
          end else begin
            read_req_next = can_issue;
          end
        end
      end

      DRAIN: begin
        if (outstanding_reg == '0) begin
          frame_done_next = 1'b1;
          state_next      = IDLE;
          // Release this buffer only when another frame is ready to replace
          // it; otherwise the same frame is shown again.
          if (rr_found) begin
            buffer_clear_next[sel_reg] = 1'b1;
            sel_next                   = rr_idx;
          end
        end
      end

      TEST_ISSUE: begin
        if (accept) begin
          read_req_next = 1'b0;
          state_next    = TEST_WAIT;
        end
      end

      TEST_WAIT: begin
        if (ddr3_avl_read_data_valid) begin
          test_rd_data_next = ddr3_avl_read_data;
          test_rd_done_next = 1'b1;
          state_next        = IDLE;
        end
      end

      default: begin
        state_next    = IDLE;
        read_req_next = 1'b0;
      end
    endcase

    // Debug requests are latched in any state; a newer one replaces the address.
    if (test_rd) begin
      test_pending_next = 1'b1;
      test_addr_next    = test_addr;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge ddr3_clk) begin
    if (ddr3_reset) begin
      state_reg        <= IDLE;
      sel_reg          <= '0;
      addr_reg         <= '0;
      size_reg         <= '0;
      read_req_reg     <= 1'b0;
      burst_count_reg  <= '0;
      outstanding_reg  <= '0;
      test_pending_reg <= 1'b0;
      test_addr_reg    <= '0;
      test_rd_data_reg <= '0;
      buffer_clear_reg <= '0;
      frame_done_reg   <= 1'b0;
      test_rd_done_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      sel_reg          <= sel_next;
      addr_reg         <= addr_next;
      size_reg         <= size_next;
      read_req_reg     <= read_req_next;
      burst_count_reg  <= burst_count_next;
      outstanding_reg  <= outstanding_next;
      test_pending_reg <= test_pending_next;
      test_addr_reg    <= test_addr_next;
      test_rd_data_reg <= test_rd_data_next;
      buffer_clear_reg <= buffer_clear_next;
      frame_done_reg   <= frame_done_next;
      test_rd_done_reg <= test_rd_done_next;
    end
  end

  assign ddr3_avl_read_req   = read_req_reg;
  assign ddr3_avl_burstbegin = read_req_reg;
  assign ddr3_avl_size       = size_reg;
  assign ddr3_avl_addr       = addr_reg;
  assign buffer_clear        = buffer_clear_reg;
  assign frame_done          = frame_done_reg;
  assign test_rd_data        = test_rd_data_reg;
  assign test_rd_done        = test_rd_done_reg;
  assign busy                = (state_reg != IDLE);
  // The debug beat must not reach the pixel pipeline.
  assign pix_data_valid      = ddr3_avl_read_data_valid && (state_reg != TEST_WAIT);

endmodule

// File: doc/ddr3_frame_reader.md
DDR3_FRAME_READER -- requirements
Module: ddr3_frame_reader

Interface
REQ-001 Parameters (name, default, meaning):
- NUM_BUFFERS, 4, frame buffers, 2..8
- IMAGE_WIDTH, 1280, pixels per line
- IMAGE_HEIGHT, 1024, lines per frame
- PIXELS_PER_WORD, 4, pixels per 128-bit word
- BURST_LEN, 4, beats per burst, 1..8
- MAX_OUTSTANDING, 32, maximum in-flight beats, a multiple of BURST_LEN
REQ-002 Ports (name, direction, width, meaning):
- ddr3_clk, in, 1, sole clock
- ddr3_reset, in, 1, synchronous active-high reset
- buffer_full, in, NUM_BUFFERS, level: buffer holds a complete frame
- buffer_offset, in, 26*NUM_BUFFERS, base word address per buffer; buffer i occupies bits [26i+25:26i]
- buffer_clear, out, NUM_BUFFERS, one-cycle release pulse per buffer
- frame_done, out, 1, one-cycle pulse at frame completion
- busy, out, 1, state not IDLE
- test_rd, in, 1, single-beat debug read request pulse
- test_addr, in, 26, debug read address
- test_rd_data, out, 128, last debug read data
- test_rd_done, out, 1, one-cycle pulse when test_rd_data updates
- data_fifo_almost_full, in, 1, downstream back-pressure
- ddr3_avl_ready, in, 1, Avalon command accept
- ddr3_avl_burstbegin, out, 1, identical to ddr3_avl_read_req
- ddr3_avl_read_req, out, 1, read command valid
- ddr3_avl_size, out, 4, burst beats
- ddr3_avl_addr, out, 26, command address
- ddr3_avl_read_data_valid, in, 1, return beat valid
- ddr3_avl_read_data, in, 128, return beat
- pix_data_valid, out, 1, ddr3_avl_read_data_valid gated off during TEST_WAIT (combinational)

Function
REQ-003 WORDS = IMAGE_WIDTH*IMAGE_HEIGHT/PIXELS_PER_WORD; BURSTS = WORDS/BURST_LEN; elaboration error if either division is inexact.
REQ-004 Command accepted when read_req && ddr3_avl_ready; read_req, addr and size held stable until accepted.
REQ-005 States: IDLE, ISSUE, DRAIN, TEST_ISSUE, TEST_WAIT.
REQ-006 test_rd pulse in any state sets test_pending and latches test_addr; a later pulse before service overwrites the address.
REQ-007 IDLE priority: (1) test_pending -> TEST_ISSUE with addr=latched address, size=1, read_req=1, test_pending cleared; (2) buffer_full[sel] -> ISSUE with addr=offset[sel], size=BURST_LEN, burst_count=0; (3) other full buffer -> sel = first full index after sel, round-robin modulo NUM_BUFFERS, remain IDLE one cycle.
REQ-008 ISSUE: read_req asserted only while data_fifo_almost_full=0 and outstanding+BURST_LEN <= MAX_OUTSTANDING; deassertion allowed only when no command is pending acceptance.
REQ-009 On each accept: addr += BURST_LEN (mod 2^26 wrap), burst_count += 1; the accept of burst BURSTS-1 -> DRAIN.
REQ-010 outstanding counter: +BURST_LEN on accept, -1 per read_data_valid, both in the same cycle -> net change; never exceeds MAX_OUTSTANDING.
REQ-011 DRAIN: when outstanding==0 -> frame_done pulse and search for another full buffer j != sel in round-robin order; if found: buffer_clear[sel] pulse and sel=j; if none: sel unchanged, no clear (frame repeats); -> IDLE.
REQ-012 TEST_ISSUE: on accept -> TEST_WAIT. TEST_WAIT: on first read_data_valid -> capture data into test_rd_data, pulse test_rd_done, -> IDLE.
REQ-013 A test read never interrupts a frame; it is serviced at the next IDLE.
REQ-014 buffer_full deasserting mid-frame does not abort the frame.

Reset
REQ-015 While ddr3_reset=1 at a ddr3_clk edge: state=IDLE, sel=0, addr=0, size=0, read_req=burstbegin=0, outstanding=0, burst_count=0, test_pending=0, test_rd_data=0, buffer_clear=0, frame_done=0, test_rd_done=0.
REQ-016 Reset mid-operation abandons in-flight beats; beats returning after reset release are not counted.

Verification
REQ-017 Scenario 1, NUM_BUFFERS=2, 16x4 image, BURST_LEN=4, buffer_full=01, ready=1 -> 4 bursts at offset0+{0,4,8,12}, frame_done once, no buffer_clear, frame restarts.
REQ-018 Scenario 2, buffer_full=11 during frame 0 -> buffer_clear=01 after drain, then bursts from offset1.
REQ-019 Scenario 3, data_fifo_almost_full=1 mid-frame with MAX_OUTSTANDING=8 and data held back -> at most 2 accepts, read_req low, burst_count frozen; resumes after release.
REQ-020 Scenario 4, test_rd with addr 0x123 during ISSUE -> no effect until frame ends; then size=1 read at 0x123, test_rd_data equals returned word, test_rd_done one pulse, pix_data_valid low for that beat.
REQ-021 Scenario 5, ready low for 5 cycles on the first command -> addr, size and read_req stable throughout; single accept.
REQ-022 Scenario 6, reset asserted in DRAIN with outstanding=6 -> all outputs at reset values next cycle; IDLE behaviour correct afterwards.
